// File: rtl/fetch_pc_gen_pkg.sv
// Shared definitions for the instruction-fetch front end: datapath width,
// default reset vector, the NOP used to fill an empty slot, and fetch states.
package fetch_pc_gen_pkg;

  localparam int          DEF_XLEN         = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen_pc_next_mux.sv
// Next-PC select: sequential pc_q+4, or the redirect target with its low two
// bits forced to zero so fetch always stays word aligned.
module pc_next_mux
  import fetch_pc_gen_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic [XLEN-1:0] pc_q,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            sel,
  output logic [XLEN-1:0] pc_next
);

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target_aligned;

  assign pc_plus4       = pc_q + XLEN'(4);
  assign target_aligned = {redirect_pc[XLEN-1:2], 2'b00};
  assign pc_next        = sel ? target_aligned : pc_plus4;

endmodule

// File: rtl/fetch_pc_gen.sv
// Instruction-fetch front end: owns the PC, keeps one memory request in
// flight at most, buffers the returned word in a single slot for decode and
// applies redirects from execute, which override everything else.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int          XLEN         = DEF_XLEN,
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_instr_o,
  output logic            pc_sel_o,
  output logic            misalign_o
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_next;
  logic            handshake;
  logic            load;
  logic            consume;

  // A new request may only go out when the slot will be free to receive it.
  assign imem_req_o  = (state_q == S_REQ) && (!if_valid_o || !stall_i);
  assign imem_addr_o = pc_q;
  assign handshake   = imem_req_o && imem_gnt_i;
  assign load        = (state_q == S_WAIT) && imem_rvalid_i && !redirect_i;
  assign consume     = if_valid_o && !stall_i;
  assign pc_sel_o    = redirect_i && rst_n;

  pc_next_mux #(
    .XLEN(XLEN)
  ) u_pc_next_mux (
    .pc_q        (pc_q),
    .redirect_pc (redirect_pc_i),
    .sel         (pc_sel_o),
    .pc_next     (pc_next)
  );

  // Fetch sequencing; a redirect turns any in-flight request into a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
    end else begin
      case (state_q)
        S_BOOT:  state_q <= S_REQ;
        S_REQ: begin
          if (handshake) begin
            state_q <= redirect_i ? S_DRAIN : S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            state_q <= S_REQ;
          end else if (redirect_i) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid_i) begin
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_BOOT;
      endcase
    end
  end

  // PC advances by one word on each accepted response, or jumps on redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VECTOR;
    end else if (redirect_i || load) begin
      pc_q <= pc_next;
    end
  end

  // Output slot: flush on redirect, fill on response, empty when consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid_o <= 1'b0;
      if_pc_o    <= '0;
      if_instr_o <= NOP_INSTR;
    end else if (redirect_i) begin
      if_valid_o <= 1'b0;
    end else if (load) begin
      if_valid_o <= 1'b1;
      if_pc_o    <= pc_q;
      if_instr_o <= imem_rdata_i;
    end else if (consume) begin
      if_valid_o <= 1'b0;
    end
  end

  // One-cycle flag for a redirect target that was not word aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: a memory responder returns 32'hAAAA_0000+addr, the
// stimulus side keeps a program-order model of the PCs decode should see, and
// a monitor pops that model whenever decode consumes the slot.
module tb_fetch_pc_gen;
  import fetch_pc_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        pc_sel_o;
  logic        misalign_o;

  fetch_pc_gen #(
    .XLEN(32),
    .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_pc_o       (if_pc_o),
    .if_instr_o    (if_instr_o),
    .pc_sel_o      (pc_sel_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          consumed = 0;
  logic [31:0] expQ[$];
  logic [31:0] nextPc = 32'h0000_0000;
  bit          flushPending = 1'b0;
  logic [31:0] flushTarget = '0;
  bit          expSel = 1'b0;
  bit          expMis = 1'b0;
  bit          prevMis = 1'b0;
  bit          monOn = 1'b0;
  bit          memRandom = 1'b0;
  int          memLatency = 1;
  int          gntHold = 0;
  bit          memPending = 1'b0;
  int          memCount = 0;
  logic [31:0] memData = '0;
  bit          holdPrev = 1'b0;
  bit          prevRedir = 1'b0;
  logic [31:0] prevAddr = '0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'hAAAA_0000 + a;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; keeps the program-order model in step with redirects.
  task automatic applyStimulus(input bit redir, input logic [31:0] tgt, input bit stl);
    @(posedge clk);
    #1;
    if (flushPending) begin
      expQ.delete();
      nextPc = flushTarget;
      flushPending = 1'b0;
    end
    while (expQ.size() < 8) begin
      expQ.push_back(nextPc);
      nextPc = nextPc + 32'd4;
    end
    redirect_i    = redir;
    redirect_pc_i = tgt;
    stall_i       = stl;
    expSel        = redir;
    expMis        = prevMis;
    prevMis       = redir && (tgt[1:0] != 2'b00);
    if (redir) begin
      flushPending = 1'b1;
      flushTarget  = {tgt[31:2], 2'b00};
    end
  endtask

  task automatic findGrant(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0);
      #1;
      if (imem_req_o && imem_gnt_i) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Memory responder: drives grant and the delayed response each cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      imem_rvalid_i = 1'b0;
      if (memPending) begin
        memCount--;
        if (memCount == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = memData;
          memPending    = 1'b0;
        end
      end
      if (gntHold > 0) begin
        imem_gnt_i = 1'b0;
        gntHold--;
      end else begin
        imem_gnt_i = memRandom ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  // Memory responder: captures accepted requests.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && imem_req_o && imem_gnt_i) begin
        checkOutput("one_outstanding", {31'b0, memPending}, 32'h0);
        memPending = 1'b1;
        memCount   = memRandom ? int'($urandom_range(1, 3)) : memLatency;
        memData    = memWord(imem_addr_o);
      end
    end
  end

  // Monitor: scoreboard pop on consumption plus per-cycle protocol checks.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (monOn) begin
        if (if_valid_o && !stall_i) begin
          consumed++;
          if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL scoreboard_empty: got pc %h, expected nothing queued", if_pc_o);
          end else begin
            e = expQ.pop_front();
            checkOutput("if_pc", if_pc_o, e);
            checkOutput("if_instr", if_instr_o, memWord(e));
          end
        end
        if (if_valid_o && stall_i) begin
          checkOutput("req_while_stalled", {31'b0, imem_req_o}, 32'h0);
        end
        checkOutput("pc_sel", {31'b0, pc_sel_o}, {31'b0, expSel});
        checkOutput("misalign", {31'b0, misalign_o}, {31'b0, expMis});
        if (holdPrev && !prevRedir) begin
          checkOutput("req_held", {31'b0, imem_req_o}, 32'h1);
          checkOutput("addr_held", imem_addr_o, prevAddr);
        end
        holdPrev  = imem_req_o && !imem_gnt_i;
        prevAddr  = imem_addr_o;
        prevRedir = redirect_i;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "[TB] timeout");
  end

  // Main sequence: directed scenarios, then randomized traffic.
  initial begin
    logic [31:0] holdPc;
    logic [31:0] holdInstr;
    logic [31:0] gntAddr;
    int          c0;
    bit          found;

    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_req", {31'b0, imem_req_o}, 32'h0);
    checkOutput("reset_valid", {31'b0, if_valid_o}, 32'h0);
    checkOutput("reset_if_pc", if_pc_o, 32'h0);
    checkOutput("reset_if_instr", if_instr_o, 32'h0000_0013);
    checkOutput("reset_misalign", {31'b0, misalign_o}, 32'h0);
    checkOutput("reset_addr", imem_addr_o, 32'h0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    monOn = 1'b1;
    checkOutput("boot_no_req", {31'b0, imem_req_o}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("first_req", {31'b0, imem_req_o}, 32'h1);
    checkOutput("first_addr", imem_addr_o, 32'h0);

    // Zero-wait memory: one instruction every two cycles.
    repeat (6) applyStimulus(1'b0, 32'h0, 1'b0);
    c0 = consumed;
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("zero_wait_rate", 32'(consumed - c0), 32'd4);

    // Stall with a full slot: contents held, no request.
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      if (if_valid_o) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("stall_slot_full", {31'b0, found}, 32'h1);
    holdPc    = if_pc_o;
    holdInstr = if_instr_o;
    repeat (4) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      #1;
      checkOutput("stall_hold_pc", if_pc_o, holdPc);
      checkOutput("stall_hold_instr", if_instr_o, holdInstr);
      checkOutput("stall_no_req", {31'b0, imem_req_o}, 32'h0);
    end

    // Release the stall while the memory withholds grant for 3 cycles.
    gntHold = 3;
    applyStimulus(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("req_on_release", {31'b0, imem_req_o}, 32'h1);
    gntAddr = imem_addr_o;
    checkOutput("release_addr", gntAddr, holdPc + 32'd4);
    repeat (2) begin
      applyStimulus(1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("gnt_delay_addr", imem_addr_o, gntAddr);
      checkOutput("gnt_delay_req", {31'b0, imem_req_o}, 32'h1);
    end

    // Redirect during WAIT, old response arriving one cycle later.
    memLatency = 2;
    findGrant(found);
    checkOutput("wait_grant_found", {31'b0, found}, 32'h1);
    applyStimulus(1'b1, 32'h0000_0100, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("drain_no_valid", {31'b0, if_valid_o}, 32'h0);
    checkOutput("drain_no_req", {31'b0, imem_req_o}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("after_drain_valid", {31'b0, if_valid_o}, 32'h0);
    checkOutput("after_drain_req", {31'b0, imem_req_o}, 32'h1);
    checkOutput("after_drain_addr", imem_addr_o, 32'h0000_0100);

    // Redirect coincident with the response.
    memLatency = 1;
    findGrant(found);
    checkOutput("coinc_grant_found", {31'b0, found}, 32'h1);
    applyStimulus(1'b1, 32'h0000_0200, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("coinc_no_load", {31'b0, if_valid_o}, 32'h0);
    checkOutput("coinc_req", {31'b0, imem_req_o}, 32'h1);
    checkOutput("coinc_addr", imem_addr_o, 32'h0000_0200);

    // Misaligned redirect target.
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0102, 1'b0);
    #1;
    checkOutput("misalign_pc_sel", {31'b0, pc_sel_o}, 32'h1);
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b0);

    // Randomized traffic: stalls, redirects, random grant and latency.
    memRandom = 1'b1;
    c0 = consumed;
    repeat (1500) begin
      applyStimulus(($urandom_range(0, 15) == 0), $urandom, ($urandom_range(0, 2) == 0));
    end
    memRandom = 1'b0;
    repeat (10) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("random_progress", {31'b0, (consumed - c0) >= 100}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
